// File: rtl/regfile_pkg.sv
// Shared widths, state encoding and reset data value for the integer pipe register file.
package regfile_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned FLG_W  = 8;

  localparam logic [DATA_W-1:0] RST_DATA = '0;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StRun   = 2'd1,
    StExt   = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port with same-cycle writeback forwarding.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DW     = DATA_W,
  parameter int unsigned SW     = SEL_W,
  parameter int unsigned NR     = 2 ** SW,
  parameter bit          R0ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SW-1:0]    sel,
  input  logic [NR*DW-1:0] regsFlat,
  input  logic             fwdEn,
  input  logic [SW-1:0]    fwdSel,
  input  logic [DW-1:0]    fwdDat,
  output logic [DW-1:0]    dat
);

  logic [DW-1:0] datD;

  always_comb begin
    datD = dat;
    if (en) begin
      if (fwdEn && (fwdSel == sel)) begin
        datD = fwdDat;
      end else begin
        datD = regsFlat[int'(sel)*DW +: DW];
      end
      // Hardwired zero overrides forwarding as well.
      if (R0ZERO && (sel == '0)) begin
        datD = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat <= DW'(RST_DATA);
    end else begin
      dat <= datD;
    end
  end

endmodule

// File: rtl/regfile_resp.sv
// Register file responder: two read ports, pipe writeback, flags and an arbitrated external port.
// Define REGFILE_R0_ZERO_EN to make register 0 read as zero and discard writes to it.
module regfile_resp
  import regfile_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned SW = SEL_W,
  parameter int unsigned FW = FLG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] aSel,
  input  logic [SW-1:0] bSel,
  output logic [DW-1:0] aDat,
  output logic [DW-1:0] bDat,
  input  logic [SW-1:0] cSel,
  input  logic [DW-1:0] cDat,
  input  logic          cWri,
  input  logic [FW-1:0] flgIn,
  input  logic          flgWri,
  output logic [FW-1:0] flgOut,
  output logic          regWt,
  input  logic          extReq,
  input  logic          extWe,
  input  logic [SW-1:0] extSel,
  input  logic [DW-1:0] extDin,
  output logic [DW-1:0] extDout,
  output logic          extAck
);

  localparam int unsigned NREGS = 2 ** SW;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  state_e        stateQ, stateD;
  logic [SW-1:0] clrCnt;
  logic [DW-1:0] regs [NREGS];
  logic [NREGS*DW-1:0] regsFlat;

  logic active;
  logic extDo;
  logic pipeWr;
  logic extWr;

  for (genvar i = 0; i < NREGS; i++) begin : gen_flat
    assign regsFlat[i*DW +: DW] = regs[i];
  end

  assign active = (stateQ != StClear);
  assign regWt  = (stateQ != StRun);
  // The external access completes only in an EXT cycle the pipe leaves free.
  assign extDo  = (stateQ == StExt) && !cWri;
  assign pipeWr = active && cWri && !(R0Zero && (cSel == '0));
  assign extWr  = extDo && extWe && !(R0Zero && (extSel == '0));

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StClear: if (clrCnt == SW'(NREGS - 1)) stateD = StRun;
      StRun:   if (extReq && !cWri) stateD = StExt;
      StExt:   if (!cWri) stateD = StRun;
      default: stateD = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= StClear;
      clrCnt  <= '0;
      flgOut  <= '0;
      extDout <= DW'(RST_DATA);
      extAck  <= 1'b0;
    end else begin
      stateQ <= stateD;
      extAck <= extDo;
      if (stateQ == StClear) begin
        clrCnt <= clrCnt + 1'b1;
      end
      if (active && flgWri) begin
        flgOut <= flgIn;
      end
      if (extDo && !extWe) begin
        extDout <= regs[extSel];
      end
    end
  end

  // Array has no reset of its own; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (stateQ == StClear) begin
        regs[clrCnt] <= DW'(RST_DATA);
      end else if (pipeWr) begin
        regs[cSel] <= cDat;
      end else if (extWr) begin
        regs[extSel] <= extDin;
      end
    end
  end

  regfile_rdport #(
    .DW     (DW),
    .SW     (SW),
    .NR     (NREGS),
    .R0ZERO (R0Zero)
  ) u_rdport_a (
    .clk      (clk),
    .rst      (rst),
    .en       (active),
    .sel      (aSel),
    .regsFlat (regsFlat),
    .fwdEn    (cWri),
    .fwdSel   (cSel),
    .fwdDat   (cDat),
    .dat      (aDat)
  );

  regfile_rdport #(
    .DW     (DW),
    .SW     (SW),
    .NR     (NREGS),
    .R0ZERO (R0Zero)
  ) u_rdport_b (
    .clk      (clk),
    .rst      (rst),
    .en       (active),
    .sel      (bSel),
    .regsFlat (regsFlat),
    .fwdEn    (cWri),
    .fwdSel   (cSel),
    .fwdDat   (cDat),
    .dat      (bDat)
  );

endmodule

// File: tb/tb_regfile_resp.sv
// Directed self-checking bench for regfile_resp.
module tb_regfile_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  aSel, bSel, cSel, extSel;
  logic [15:0] aDat, bDat, cDat, extDin, extDout;
  logic        cWri, flgWri, regWt, extReq, extWe, extAck;
  logic [7:0]  flgIn, flgOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_resp dut (
    .clk     (clk),
    .rst     (rst),
    .aSel    (aSel),
    .bSel    (bSel),
    .aDat    (aDat),
    .bDat    (bDat),
    .cSel    (cSel),
    .cDat    (cDat),
    .cWri    (cWri),
    .flgIn   (flgIn),
    .flgWri  (flgWri),
    .flgOut  (flgOut),
    .regWt   (regWt),
    .extReq  (extReq),
    .extWe   (extWe),
    .extSel  (extSel),
    .extDin  (extDin),
    .extDout (extDout),
    .extAck  (extAck)
  );

  // Drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Counts regWt-high samples after rst drops; expects exactly 8 and no stray ack.
  task automatic count_clear(input string name);
    int n = 0;
    logic sawAck = 1'b0;
    while (regWt && n < 20) begin
      n++;
      if (extAck) sawAck = 1'b1;
      tick();
    end
    chk({name, "_len"}, 16'(n), 16'd8);
    chk({name, "_ack"}, {15'd0, sawAck}, 16'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    aSel = 3'd5; bSel = 3'd0; cSel = 3'd5; cDat = 16'hDEAD; cWri = 1'b0;
    flgIn = 8'h00; flgWri = 1'b0;
    extReq = 1'b0; extWe = 1'b0; extSel = 3'd0; extDin = 16'h0;
    tick();
    tick();
    chk("rst_regWt", {15'd0, regWt}, 16'd1);
    chk("rst_aDat", aDat, 16'h0000);
    chk("rst_flg", {8'd0, flgOut}, 16'h0000);
    chk("rst_ack", {15'd0, extAck}, 16'd0);
    rst = 1'b0;
    // Writes during CLEAR must be ignored.
    cWri = 1'b1;
    flgWri = 1'b1; flgIn = 8'hFF;
    count_clear("clear");
    cWri = 1'b0; flgWri = 1'b0;
    chk("clear_flg", {8'd0, flgOut}, 16'h0000);
    tick();
    chk("clear_r5", aDat, 16'h0000);
  endtask

  task automatic test_write_read();
    aSel = 3'd0;
    cWri = 1'b1; cSel = 3'd3; cDat = 16'hBEEF;
    tick();
    cWri = 1'b0; aSel = 3'd3;
    tick();
    chk("wr_rd_a", aDat, 16'hBEEF);
  endtask

  task automatic test_forward();
    cWri = 1'b1; cSel = 3'd2; cDat = 16'h1234; aSel = 3'd2; bSel = 3'd2;
    tick();
    cWri = 1'b0;
    chk("fwd_a", aDat, 16'h1234);
    chk("fwd_b", bDat, 16'h1234);
    bSel = 3'd3;
    tick();
    chk("fwd_hold_a", aDat, 16'h1234);
    chk("fwd_other_b", bDat, 16'hBEEF);
  endtask

  task automatic test_flags();
    flgWri = 1'b1; flgIn = 8'h5A;
    tick();
    flgWri = 1'b0; flgIn = 8'h00;
    chk("flg_set", {8'd0, flgOut}, 16'h005A);
    tick();
    chk("flg_hold", {8'd0, flgOut}, 16'h005A);
  endtask

  task automatic test_arbitration();
    int n;
    cWri = 1'b1; cSel = 3'd1; cDat = 16'h1111;
    extReq = 1'b1; extWe = 1'b1; extSel = 3'd4; extDin = 16'hA5A5;
    tick();
    chk("arb_wait1", {15'd0, regWt}, 16'd0);
    cDat = 16'h2222;
    tick();
    chk("arb_wait2", {15'd0, regWt}, 16'd0);
    cWri = 1'b0;
    tick();
    chk("arb_ext_wt", {15'd0, regWt}, 16'd1);
    chk("arb_ext_ack", {15'd0, extAck}, 16'd0);
    tick();
    chk("arb_ack", {15'd0, extAck}, 16'd1);
    chk("arb_run", {15'd0, regWt}, 16'd0);
    extReq = 1'b0;
    tick();
    chk("arb_ack_pulse", {15'd0, extAck}, 16'd0);
    // Read back via external port.
    extReq = 1'b1; extWe = 1'b0; extSel = 3'd4;
    n = 0;
    tick();
    while (!extAck && n < 10) begin n++; tick(); end
    extReq = 1'b0;
    chk("ext_rd_lat", 16'(n), 16'd1);
    chk("ext_rd_dat", extDout, 16'hA5A5);
    aSel = 3'd1;
    tick();
    chk("pipe_last_wr", aDat, 16'h2222);
    chk("ext_dout_hold", extDout, 16'hA5A5);
  endtask

  task automatic test_ext_collision();
    extReq = 1'b1; extWe = 1'b0; extSel = 3'd3;
    tick();
    chk("col_ext", {15'd0, regWt}, 16'd1);
    cWri = 1'b1; cSel = 3'd6; cDat = 16'h6666;
    tick();
    chk("col_stay", {15'd0, regWt}, 16'd1);
    chk("col_noack", {15'd0, extAck}, 16'd0);
    cWri = 1'b0;
    tick();
    chk("col_ack", {15'd0, extAck}, 16'd1);
    chk("col_dout", extDout, 16'hBEEF);
    extReq = 1'b0;
    aSel = 3'd6;
    tick();
    chk("col_pipe_wr", aDat, 16'h6666);
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int firstAck = -1;
    int secondAck = -1;
    extReq = 1'b1; extWe = 1'b0; extSel = 3'd6;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (extAck) begin
        acks++;
        if (firstAck < 0) firstAck = c; else secondAck = c;
      end
    end
    extReq = 1'b0;
    chk("b2b_acks", 16'(acks), 16'd2);
    chk("b2b_spacing", 16'(secondAck - firstAck), 16'd2);
    tick();
  endtask

  task automatic test_reset_mid_ext();
    extReq = 1'b1; extWe = 1'b1; extSel = 3'd4; extDin = 16'h7777;
    tick();
    chk("rme_ext", {15'd0, regWt}, 16'd1);
    rst = 1'b1;
    tick();
    chk("rme_noack", {15'd0, extAck}, 16'd0);
    rst = 1'b0; extReq = 1'b0;
    count_clear("rme_clear");
    aSel = 3'd4;
    tick();
    chk("rme_r4", aDat, 16'h0000);
  endtask

  task automatic test_r0();
    logic [15:0] exp;
`ifdef REGFILE_R0_ZERO_EN
    exp = 16'h0000;
`else
    exp = 16'hFFFF;
`endif
    cWri = 1'b1; cSel = 3'd0; cDat = 16'hFFFF; aSel = 3'd0; bSel = 3'd0;
    tick();
    cWri = 1'b0;
    chk("r0_fwd", bDat, exp);
    tick();
    chk("r0_read", aDat, exp);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_forward();
    test_flags();
    test_arbitration();
    test_ext_collision();
    test_back_to_back();
    test_reset_mid_ext();
    test_r0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
